// File: rtl/deparser_layer.sv
// deparser_layer: writes modified key fields from a metadata vector back into a
// header at rule-configured 16-bit word offsets. Two-stage pipeline
// (select, then mux). Rules are staged in shadow registers and committed
// atomically during an idle header cycle.
//
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_rule_wren/rden/addr/wdata       32-bit rule bus (write / read request)
//   o_rule_rdata_valid, o_rule_rdata  registered read response (1 cycle)
//   i_head_in_valid, i_head_in        header beat in
//   i_meta_valid, i_meta              modified fields, field 0 in the MSBs
//   o_head_out_valid, o_head_out      rewritten header, 2 cycles later
module deparser_layer #(
    parameter int unsigned HEAD_WIDTH   = 512,
    parameter int unsigned FIELD_WIDTH  = 16,
    parameter int unsigned FIELD_NUM    = 4,
    parameter int unsigned OFFSET_WIDTH = 5,
    parameter int unsigned META_WIDTH   = FIELD_NUM * FIELD_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rule_wren,
    input  logic                  i_rule_rden,
    input  logic [31:0]           i_rule_addr,
    input  logic [31:0]           i_rule_wdata,
    output logic                  o_rule_rdata_valid,
    output logic [31:0]           o_rule_rdata,
    input  logic                  i_head_in_valid,
    input  logic [HEAD_WIDTH-1:0] i_head_in,
    input  logic                  i_meta_valid,
    input  logic [META_WIDTH-1:0] i_meta,
    output logic                  o_head_out_valid,
    output logic [HEAD_WIDTH-1:0] o_head_out
);

    localparam int unsigned WORD_NUM  = HEAD_WIDTH / FIELD_WIDTH;
    localparam int unsigned SEL_WIDTH = (FIELD_NUM > 1) ? $clog2(FIELD_NUM) : 1;

    localparam logic [31:0] ADDR_COMMIT = 32'h10;
    localparam logic [31:0] ADDR_STATUS = 32'h11;
    localparam logic [31:0] ADDR_COUNT  = 32'h12;

    typedef struct packed {
        logic                    en;
        logic [OFFSET_WIDTH-1:0] off;
    } rule_t;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                   state;
    rule_t                    shadow     [FIELD_NUM];
    rule_t                    shadow_nxt [FIELD_NUM];
    rule_t                    active     [FIELD_NUM];
    logic [31:0]              out_count;

    logic                     commit_wr;
    logic [31:0]              rdata_c;

    logic [FIELD_WIDTH-1:0]   fields_c   [FIELD_NUM];
    logic [SEL_WIDTH-1:0]     sel_c      [WORD_NUM];
    logic [WORD_NUM-1:0]      hit_c;

    logic                     valid_s1;
    logic [HEAD_WIDTH-1:0]    head_s1;
    logic [FIELD_WIDTH-1:0]   fields_s1  [FIELD_NUM];
    logic [SEL_WIDTH-1:0]     sel_s1     [WORD_NUM];
    logic [WORD_NUM-1:0]      hit_s1;
    logic [HEAD_WIDTH-1:0]    head_mux_c;

    // Write-data bits outside the rule encoding are don't-care.
    logic unused_wdata;
    assign unused_wdata = ^i_rule_wdata[30:OFFSET_WIDTH];

    assign commit_wr = i_rule_wren && (i_rule_addr == ADDR_COMMIT) && i_rule_wdata[0];

    // Shadow next value; a write in the commit cycle is part of the commit.
    always_comb begin
        for (int j = 0; j < FIELD_NUM; j++) begin
            shadow_nxt[j] = shadow[j];
            if (i_rule_wren && (i_rule_addr == 32'(j))) begin
                shadow_nxt[j].en  = i_rule_wdata[31];
                shadow_nxt[j].off = i_rule_wdata[OFFSET_WIDTH-1:0];
            end
        end
    end

    // Shadow rule registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < FIELD_NUM; j++) shadow[j] <= '0;
        end else begin
            for (int j = 0; j < FIELD_NUM; j++) shadow[j] <= shadow_nxt[j];
        end
    end

    // Commit FSM: wait for a gap in header traffic, then swap rules in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            for (int j = 0; j < FIELD_NUM; j++) active[j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit_wr) state <= PENDING;
                end
                PENDING: begin
                    if (!i_head_in_valid) begin
                        state <= IDLE;
                        for (int j = 0; j < FIELD_NUM; j++) active[j] <= shadow_nxt[j];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output beat counter; a clear write beats a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_count <= '0;
        end else if (i_rule_wren && (i_rule_addr == ADDR_COUNT)) begin
            out_count <= '0;
        end else if (o_head_out_valid) begin
            out_count <= out_count + 32'd1;
        end
    end

    // Rule-bus read mux, sampled from pre-write register state.
    always_comb begin
        rdata_c = '0;
        for (int j = 0; j < FIELD_NUM; j++) begin
            if (i_rule_addr == 32'(j)) begin
                rdata_c = {shadow[j].en, {(31 - OFFSET_WIDTH){1'b0}}, shadow[j].off};
            end
        end
        if (i_rule_addr == ADDR_STATUS) rdata_c = {31'd0, state == PENDING};
        if (i_rule_addr == ADDR_COUNT)  rdata_c = out_count;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rule_rdata_valid <= 1'b0;
            o_rule_rdata       <= '0;
        end else begin
            o_rule_rdata_valid <= i_rule_rden;
            if (i_rule_rden) o_rule_rdata <= rdata_c;
        end
    end

    // Stage 1 select: highest-index enabled rule matching each word wins.
    always_comb begin
        for (int j = 0; j < FIELD_NUM; j++) begin
            fields_c[j] = i_meta[META_WIDTH - j*FIELD_WIDTH - 1 -: FIELD_WIDTH];
        end
        for (int k = 0; k < WORD_NUM; k++) begin
            sel_c[k] = '0;
            hit_c[k] = 1'b0;
            for (int j = 0; j < FIELD_NUM; j++) begin
                if (active[j].en && (32'(active[j].off) == 32'(k))) begin
                    sel_c[k] = SEL_WIDTH'(j);
                    hit_c[k] = 1'b1;
                end
            end
            hit_c[k] = hit_c[k] & i_meta_valid;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_s1 <= 1'b0;
            head_s1  <= '0;
            hit_s1   <= '0;
            for (int j = 0; j < FIELD_NUM; j++) fields_s1[j] <= '0;
            for (int k = 0; k < WORD_NUM; k++)  sel_s1[k]    <= '0;
        end else begin
            valid_s1 <= i_head_in_valid;
            head_s1  <= i_head_in;
            hit_s1   <= hit_c;
            for (int j = 0; j < FIELD_NUM; j++) fields_s1[j] <= fields_c[j];
            for (int k = 0; k < WORD_NUM; k++)  sel_s1[k]    <= sel_c[k];
        end
    end

    // Stage 2 mux: word 0 occupies the most significant slice.
    always_comb begin
        head_mux_c = head_s1;
        for (int k = 0; k < WORD_NUM; k++) begin
            if (hit_s1[k]) begin
                head_mux_c[(WORD_NUM-1-k)*FIELD_WIDTH +: FIELD_WIDTH] = fields_s1[sel_s1[k]];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_head_out_valid <= 1'b0;
            o_head_out       <= '0;
        end else begin
            o_head_out_valid <= valid_s1;
            o_head_out       <= head_mux_c;
        end
    end

endmodule

// File: doc/deparser_layer.md
# deparser_layer

Write-back counterpart of the per-layer parser: takes a header word plus a metadata vector of modified key fields and re-inserts each field into the header at a rule-configured 16-bit word offset, producing the rewritten header two cycles later. One instance sits per protocol layer in the deparser pipeline and mirrors the parser layer's field ordering, so a field extracted at offset k is written back at offset k. Insertion rules are programmed through the shared 32-bit rule bus into shadow registers and committed atomically at a gap in header traffic.

## Interface
- HEAD_WIDTH, 512: header bus width in bits; must be a multiple of FIELD_WIDTH
- FIELD_WIDTH, 16: width of one key field / header word
- FIELD_NUM, 4: number of insertable fields in the metadata vector (max 16)
- OFFSET_WIDTH, 5: word-offset width; 2^OFFSET_WIDTH >= HEAD_WIDTH/FIELD_WIDTH
- META_WIDTH, FIELD_NUM*FIELD_WIDTH: metadata width (derived)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rule_wren  in  1  rule write strobe
- i_rule_rden  in  1  rule read strobe
- i_rule_addr  in  32  rule register address
- i_rule_wdata  in  32  rule write data
- o_rule_rdata_valid  out  1  read data valid, one cycle after i_rule_rden
- o_rule_rdata  out  32  read data
- i_head_in_valid  in  1  header beat valid
- i_head_in  in  HEAD_WIDTH  header to rewrite
- i_meta_valid  in  1  metadata valid, sampled with i_head_in_valid
- i_meta  in  META_WIDTH  modified fields; field j = i_meta[META_WIDTH-j*FIELD_WIDTH-1 -: FIELD_WIDTH]
- o_head_out_valid  out  1  rewritten header valid
- o_head_out  out  HEAD_WIDTH  rewritten header

## Operation
- Word k of the header (k=0 most significant) = bits [(HEAD_WIDTH/FIELD_WIDTH-1-k)*FIELD_WIDTH +: FIELD_WIDTH], same ordering as parser candidates.
- Rule map: addr 0..FIELD_NUM-1 = shadow entry j, wdata[31]=enable, wdata[OFFSET_WIDTH-1:0]=offset; 0x10 write with wdata[0]=1 = commit request; 0x11 read = status (bit0 commit pending); 0x12 = 32-bit output counter, read returns value, any write clears it. Other addresses: writes ignored, reads return 0.
- Active entries drive insertion; shadow entries only become active on commit.
- Commit FSM: IDLE -> PENDING on commit write. PENDING -> IDLE in the first cycle with i_head_in_valid=0, copying all shadow entries to active that cycle. Back-to-back beats therefore always see one consistent rule set. Commit write while PENDING: no effect. Shadow writes while PENDING are included in the commit.
- Insertion: for each word k, select the highest-index enabled active entry j with offset==k; replace word k with field j. Words with no match pass through. Offsets >= HEAD_WIDTH/FIELD_WIDTH never match.
- i_meta_valid=0 with a valid beat: header passes unmodified (no insertion).
- Counter increments on each o_head_out_valid, wraps 0xFFFFFFFF->0; clear write in the same cycle wins.

## Timing
- Stage 1 registers head, meta-valid-qualified per-word select (field index + hit) from active rules, and valid; stage 2 registers muxed header and valid.
- Latency 2 cycles: beat at edge N appears at o_head_out at edge N+2; throughput 1 beat/cycle; no backpressure.
- Rule-bus read: o_rule_rdata_valid and o_rule_rdata registered, valid exactly one cycle after i_rule_rden; simultaneous write to the same address returns the pre-write value.
- Commit affects beats entering stage 1 at or after the cycle following the commit cycle.
- Reset (async, any time): o_head_out_valid=0, o_head_out=0, o_rule_rdata_valid=0, o_rule_rdata=0, all shadow/active entries disabled with offset 0, FSM IDLE, counter 0; in-flight beats are dropped.

## Test plan
- Reset, no rules, beat head=0x0001..0x0020 words with meta=all 0xFFFF -> output identical to input at N+2, counter reads 1.
- Shadow entry0 = enable, offset 6; commit in idle gap; beat with meta field0=0xABCD -> word 6 becomes 0xABCD, others unchanged; status reads 0 after commit.
- Entries 1 and 3 both offset 2, meta fields 0x1111/0x3333 -> word 2 = 0x3333; same beat with i_meta_valid=0 -> unmodified.
- Commit written during a 5-beat back-to-back burst -> all 5 use old rules, status bit0=1 during burst, next beat after the gap uses new rules.
- Offset 31 on entry 2 -> least significant word rewritten; offset setting irrelevant when enable=0 -> no change.
- Assert i_rst_n low mid-burst -> outputs 0 immediately, rules disabled, counter 0; rdata read of addr 0 returns 0 with valid one cycle after rden.
